// File: rtl/signed_div_seq_ctrl.sv
// signed_div_seq_ctrl: control FSM for a shared restoring signed divider.
// Sequences LOAD -> CHECK -> WIDTH x (ITER_A, ITER_B) -> FIX -> DONE and drives
// the datapath strobes as decodes of the state register. The datapath (A:Q
// shift register, divisor M, adder/subtractor, sign fix-up) lives elsewhere.
// Optional feature: define SIGNED_DIV_ABORT_EN to add an abort input that
// returns any busy state other than DONE to IDLE without a done pulse.
module signed_div_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dvd_sign,
  input  logic          dvs_sign,
  input  logic          dvs_zero,
  input  logic          rem_neg,
`ifdef SIGNED_DIV_ABORT_EN
  input  logic          abort,
`endif
  output logic          ld_dvd,
  output logic          ld_dvs,
  output logic          shift_sub,
  output logic          restore,
  output logic          set_q,
  output logic          neg_q,
  output logic          neg_r,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [CW-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ITER_A,
    S_ITER_B,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d;    // quotient must be negated at the end
  logic          sr_q, sr_d;    // remainder must be negated (dividend sign)
  logic          dbz_q, dbz_d;

  // State and context registers; synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration counter and latched sign/error context.
  // NOTE: every variable gets a hold default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          dbz_d   = 1'b0;
        end
      end
      S_LOAD: begin
        sq_d    = dvd_sign ^ dvs_sign;
        sr_d    = dvd_sign;
        cnt_d   = CNT_INIT;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dvs_zero) begin
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER_A;
        end
      end
      S_ITER_A: state_d = S_ITER_B;
      S_ITER_B: begin
        // Saturating decrement; the <= test also guarantees the loop ends
        // even if the counter were somehow zero on entry.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        state_d = (cnt_q <= CNT_ONE) ? S_FIX : S_ITER_A;
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SIGNED_DIV_ABORT_EN
    // Abort wins over the normal transition in every busy state but DONE;
    // the error flag keeps whatever it held before this cycle.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dbz_d   = dbz_q;
    end
`endif
  end

  // Moore decode of the datapath strobes and status outputs.
  always_comb begin
    ld_dvd    = 1'b0;
    ld_dvs    = 1'b0;
    shift_sub = 1'b0;
    restore   = 1'b0;
    set_q     = 1'b0;
    neg_q     = 1'b0;
    neg_r     = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_dvd = 1'b1;
        ld_dvs = 1'b1;
      end
      S_ITER_A: shift_sub = 1'b1;
      S_ITER_B: begin
        restore = rem_neg;
        set_q   = ~rem_neg;
      end
      S_FIX: begin
        neg_q = sq_q;
        neg_r = sr_q;
      end
      default: ;
    endcase
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    div_by_zero = dbz_q;
    iter_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_signed_div_seq_ctrl.sv
// Bench for signed_div_seq_ctrl with a behavioural restoring-divider datapath.
// Table rows run through a scoreboard queue; hand sequences cover start while
// busy, mid-run reset and (with SIGNED_DIV_ABORT_EN) abort.
module tb_signed_div_seq_ctrl;

  localparam int W  = 16;
  localparam int CW = $clog2(W + 1);
  localparam int DONE_CYC     = 4 + 2 * W;
  localparam int DONE_CYC_DBZ = 3;

  typedef struct {
    logic signed [W-1:0] dvd;
    logic signed [W-1:0] dvs;
    logic signed [W-1:0] q;
    logic signed [W-1:0] r;
    logic                dbz;
    logic [W-1:0]        mask;   // bit i-1 set when iteration i asserts set_q
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic          dvd_sign, dvs_sign, dvs_zero, rem_neg;
  logic          ld_dvd, ld_dvs, shift_sub, restore, set_q, neg_q, neg_r;
  logic          busy, done, div_by_zero;
  logic [CW-1:0] iter_cnt;

  // Behavioural datapath
  logic signed [W-1:0] opa, opb;
  logic [W:0]          a_m;
  logic [W-1:0]        q_m, m_m;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t exp_q[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  signed_div_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dvd_sign   (dvd_sign),
    .dvs_sign   (dvs_sign),
    .dvs_zero   (dvs_zero),
    .rem_neg    (rem_neg),
`ifdef SIGNED_DIV_ABORT_EN
    .abort      (abort),
`endif
    .ld_dvd     (ld_dvd),
    .ld_dvs     (ld_dvs),
    .shift_sub  (shift_sub),
    .restore    (restore),
    .set_q      (set_q),
    .neg_q      (neg_q),
    .neg_r      (neg_r),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .iter_cnt   (iter_cnt)
  );

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    return v[W-1] ? W'(-v) : W'(v);
  endfunction

  assign dvd_sign = opa[W-1];
  assign dvs_sign = opb[W-1];
  assign dvs_zero = (m_m == '0);
  assign rem_neg  = a_m[W];

  always @(posedge clk) begin
    if (ld_dvd) begin
      q_m <= mag(opa);
      a_m <= '0;
    end
    if (ld_dvs) m_m <= mag(opb);
    if (shift_sub) begin
      a_m <= {a_m[W-1:0], q_m[W-1]} - {1'b0, m_m};
      q_m <= {q_m[W-2:0], 1'b0};
    end
    if (restore) begin
      a_m    <= a_m + {1'b0, m_m};
      q_m[0] <= 1'b0;
    end
    if (set_q) q_m[0] <= 1'b1;
    if (neg_q) q_m <= -q_m;
    if (neg_r) a_m <= -a_m;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int q, input int r,
                              input logic z, input logic [W-1:0] m);
    vec_t v;
    v.dvd = W'(a);
    v.dvs = W'(b);
    v.q   = W'(q);
    v.r   = W'(r);
    v.dbz = z;
    v.mask = m;
    return v;
  endfunction

  function automatic logic [14:0] out_vec();
    return {ld_dvd, ld_dvs, shift_sub, restore, set_q, neg_q, neg_r,
            busy, done, div_by_zero, 5'(iter_cnt)};
  endfunction

  // One complete operation. poke > 0 pulses start again in that cycle;
  // cycle 1 is the cycle after the edge that samples start.
  task automatic run_op(input int id, input vec_t v, input int poke);
    int cyc = 0, done_cyc = 0, busy_cnt = 0, sh_cnt = 0, rest_cnt = 0;
    int negq_c = 0, negr_c = 0, excl_bad = 0, extra = 0, grp = 0, tail;
    logic [W-1:0] mask = '0;
    logic seen = 1'b0;
    logic sq;
    vec_t e;
    sq = v.dvd[W-1] ^ v.dvs[W-1];
    opa = v.dvd;
    opb = v.dvs;
    exp_q.push_back(v);
    start = 1'b1;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
      if (cyc == 1) check($sformatf("op%0d dbz cleared by start", id), 32'(div_by_zero), 0);
      if (cyc == 2) check($sformatf("op%0d iter_cnt loaded", id), 32'(iter_cnt), W);
      grp = int'(ld_dvd | ld_dvs) + int'(shift_sub) + int'(restore) + int'(set_q)
          + int'(neg_q | neg_r);
      if (grp > 1) excl_bad++;
      if (busy) busy_cnt++;
      if (shift_sub) sh_cnt++;
      if (restore) rest_cnt++;
      if (set_q && sh_cnt > 0) mask = mask | (W'(1) << (sh_cnt - 1));
      if (neg_q) negq_c = cyc;
      if (neg_r) negr_c = cyc;
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check($sformatf("op%0d scoreboard empty at done", id), 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("op%0d div_by_zero", id), 32'(div_by_zero), 32'(e.dbz));
          if (!e.dbz) begin
            check($sformatf("op%0d quotient", id), {16'h0, q_m}, {16'h0, e.q});
            check($sformatf("op%0d remainder", id), {16'h0, a_m[W-1:0]}, {16'h0, e.r});
            check($sformatf("op%0d iter_cnt at done", id), 32'(iter_cnt), 0);
          end
        end
      end
    end
    check($sformatf("op%0d done seen", id), 32'(seen), 1);
    check($sformatf("op%0d done cycle", id), done_cyc, v.dbz ? DONE_CYC_DBZ : DONE_CYC);
    check($sformatf("op%0d busy cycles", id), busy_cnt, v.dbz ? DONE_CYC_DBZ : DONE_CYC);
    check($sformatf("op%0d shift_sub count", id), sh_cnt, v.dbz ? 0 : W);
    check($sformatf("op%0d set_q pattern", id), {16'h0, mask}, {16'h0, v.mask});
    check($sformatf("op%0d restore+set_q count", id), rest_cnt + $countones(mask), v.dbz ? 0 : W);
    check($sformatf("op%0d neg_q cycle", id), negq_c, (!v.dbz && sq) ? DONE_CYC - 1 : 0);
    check($sformatf("op%0d neg_r cycle", id), negr_c, (!v.dbz && v.dvd[W-1]) ? DONE_CYC - 1 : 0);
    check($sformatf("op%0d strobe exclusivity", id), excl_bad, 0);
    // Idle tail: no second done, no re-entry, error flag held
    tail = (poke > 0) ? 40 : 2;
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || busy) extra++;
    end
    check($sformatf("op%0d quiet after done", id), extra, 0);
    check($sformatf("op%0d dbz held", id), 32'(div_by_zero), 32'(v.dbz));
  endtask

  initial begin
    int extra;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    opa   = '0;
    opb   = '0;
    a_m   = '0;
    q_m   = '0;
    m_m   = '0;

    tbl[0] = mk(100, 7, 14, 2, 1'b0, 16'h7000);
    tbl[1] = mk(-100, 7, -14, -2, 1'b0, 16'h7000);
    tbl[2] = mk(100, -7, -14, 2, 1'b0, 16'h7000);
    tbl[3] = mk(-100, -7, 14, -2, 1'b0, 16'h7000);
    tbl[4] = mk(5, 0, 0, 0, 1'b1, 16'h0000);
    tbl[5] = mk(-32768, -1, -32768, 0, 1'b0, 16'h0001);
    tbl[6] = mk(7, 100, 0, 7, 1'b0, 16'h0000);
    tbl[7] = mk(32767, 1, 32767, 0, 1'b0, 16'hFFFE);
    tbl[8] = mk(-1, 2, 0, -1, 1'b0, 16'h0000);
    tbl[9] = mk(0, 5, 0, 0, 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    check("reset outputs", 32'(out_vec()), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", 32'(out_vec()), 0);

    for (int i = 0; i < 10; i++) run_op(i, tbl[i], 0);

    // start pulsed mid-run and again while in DONE: both ignored
    run_op(10, tbl[0], 5);
    run_op(11, tbl[1], DONE_CYC);

    // Synchronous reset in cycle 10 of a run
    opa = 16'sd100;
    opb = 16'sd7;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("busy before mid-run reset", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("outputs after mid-run reset", 32'(out_vec()), 0);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("no done after reset", extra, 0);

`ifdef SIGNED_DIV_ABORT_EN
    // Abort in cycle 20, then a fresh start two cycles later
    opa = 16'sd100;
    opb = 16'sd7;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort returns to idle", 32'(busy), 0);
    check("abort clears iter_cnt", 32'(iter_cnt), 0);
    check("abort no done", 32'(done), 0);
    @(negedge clk);
    run_op(12, tbl[0], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_div_seq_ctrl.md
Name: signed_div_seq_ctrl

Overview:
- Control FSM that sequences the shared restoring signed-divider datapath (A:Q shift register, divisor register M, adder/subtractor, sign fix-up).
- Accepts a start request, loads operand magnitudes, and runs WIDTH shift/subtract/restore iterations.
- Applies quotient/remainder sign correction, detects divide-by-zero, and reports completion with a one-cycle done pulse.
- The datapath is external; this block drives only its control strobes and reads back its status bits.

Parameters:
- WIDTH, 16, operand/quotient width; number of iterations.
- CW, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dvd_sign  input  1  dividend MSB from datapath input mux.
- dvs_sign  input  1  divisor MSB.
- dvs_zero  input  1  divisor register == 0; valid from CHECK onward.
- rem_neg  input  1  sign of trial result A-M; valid in ITER_B.
- ld_dvd  output  1  load |dividend| into Q, clear A.
- ld_dvs  output  1  load |divisor| into M.
- shift_sub  output  1  shift A:Q left 1, compute A-M into A.
- restore  output  1  A <= A+M; Q[0] <= 0.
- set_q  output  1  Q[0] <= 1.
- neg_q  output  1  negate Q (two's complement).
- neg_r  output  1  negate A.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  qualifies done; holds until next start.
- iter_cnt  output  CW  remaining iterations.

Behaviour:
- Reset (any state, mid-operation included): next state IDLE; all strobes, busy, done, div_by_zero = 0; iter_cnt = 0; latched signs = 0.
- States: IDLE, LOAD, CHECK, ITER_A, ITER_B, FIX, DONE. Strobes are Moore decodes of the state register.
- IDLE: if start, go to LOAD; clear div_by_zero.
- LOAD:
  - Assert ld_dvd and ld_dvs.
  - Latch sq = dvd_sign ^ dvs_sign and sr = dvd_sign.
  - Set iter_cnt = WIDTH.
- CHECK: if dvs_zero, set div_by_zero and go to DONE; else go to ITER_A.
- ITER_A: assert shift_sub; go to ITER_B.
- ITER_B:
  - If rem_neg, assert restore; else assert set_q.
  - Decrement iter_cnt.
  - If iter_cnt == 1 at entry, go to FIX; else go to ITER_A.
- FIX: neg_q = sq; neg_r = sr (remainder takes the dividend's sign). Go to DONE.
- DONE: assert done for exactly one cycle, then go to IDLE.
- Latency, counting the cycle after the start-sampling edge as cycle 1:
  - LOAD = 1, CHECK = 2, iterations = cycles 3..2+2*WIDTH, FIX = 3+2*WIDTH, done = 4+2*WIDTH (36 for WIDTH = 16).
  - Divide-by-zero: done in cycle 3; no shift_sub, restore, set_q, neg_q or neg_r ever asserted.
- start while busy (including in DONE): ignored. Back-to-back operations need one IDLE cycle.
- Overflow (dividend = -2^(WIDTH-1), divisor = -1): no special handling; quotient wraps to -2^(WIDTH-1), done asserted normally, no error flag.
- Strobes are mutually exclusive in every cycle.
- iter_cnt never wraps below 0.

Optional Feature:
- Macro: SIGNED_DIV_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in any busy state except DONE: next state IDLE, no done pulse, div_by_zero unchanged, iter_cnt = 0.
  - abort in IDLE or DONE is ignored.
  - If abort and rst are both high, rst takes priority (identical result).
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- 100 / 7 with a behavioural datapath model (WIDTH = 16) -> set_q in iterations 13, 14, 15 only (Q = 14); A = 2; neg_q = neg_r = 0; done in cycle 36; busy high in cycles 1..36.
- -100 / 7 -> same iteration pattern; neg_q = 1 and neg_r = 1 in cycle 35; model result Q = -14, R = -2.
- 100 / -7 -> neg_q = 1, neg_r = 0; result Q = -14, R = 2. -100 / -7 -> neg_q = 0, neg_r = 1.
- Divisor 0 -> done and div_by_zero high in cycle 3; zero iteration strobes; div_by_zero stays 1 until the next accepted start.
- rst asserted in cycle 10 -> all outputs 0 next cycle; no done pulse. start pulsed in cycle 5 of a run -> ignored; exactly one done.
- With SIGNED_DIV_ABORT_EN: abort in cycle 20 -> IDLE next cycle, no done; a new start two cycles later completes normally in 36 cycles.
